// File: rtl/con_eval_unit_if.sv
// Request/response bundle between the control sequencer and the branch-condition unit.
// The sequencer drives the master side; the condition unit implements the slave side.
interface con_eval_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int COND_BITS  = 3,
  parameter int CNT_WIDTH  = 16
);
  logic                  con_in;
  logic [COND_BITS-1:0]  ir_cond;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  loop_load;
  logic [CNT_WIDTH-1:0]  loop_value;
  logic                  con_out;
  logic                  con_valid;
  logic                  busy;
  logic                  loop_zero;
  logic                  con_err;

  modport master (
    output con_in, ir_cond, bus_data, loop_load, loop_value,
    input  con_out, con_valid, busy, loop_zero, con_err
  );

  modport slave (
    input  con_in, ir_cond, bus_data, loop_load, loop_value,
    output con_out, con_valid, busy, loop_zero, con_err
  );
endinterface

// File: rtl/con_eval_unit.sv
// Branch-condition evaluator: captures a condition code and bus operand, decides the
// branch two cycles after the request, and keeps a decrement-and-branch loop counter.
module con_eval_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int COND_BITS  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic               clk,
  input  logic               clr,
  con_eval_unit_if.slave     ev
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t                state;
  logic [COND_BITS-1:0]  cap_cond;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  count_dec;
  logic [2:0]            code;
  logic                  msb;
  logic                  nonzero;
  logic                  result;

  // With a 2-bit field the code zero-extends, so codes 4-7 are unreachable.
  always_comb begin
    code      = 3'(cap_cond);
    msb       = cap_data[DATA_WIDTH-1];
    nonzero   = |cap_data;
    count_dec = count - CNT_WIDTH'(1);
    result    = 1'b0;
    case (code)
      3'd0:    result = !nonzero;
      3'd1:    result = nonzero;
      3'd2:    result = !msb;
      3'd3:    result = msb;
      3'd4:    result = 1'b1;
      3'd5:    result = 1'b0;
      3'd6:    result = !msb && nonzero;
      3'd7:    result = (count != '0) && (count_dec != '0);
      default: result = 1'b0;
    endcase
  end

  assign ev.loop_zero = (count == '0);

  // A load on the same edge as a code-7 decrement wins; the result above already
  // used the pre-load counter value.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= IDLE;
      cap_cond     <= '0;
      cap_data     <= '0;
      count        <= '0;
      ev.con_out   <= 1'b0;
      ev.con_valid <= 1'b0;
      ev.busy      <= 1'b0;
      ev.con_err   <= 1'b0;
    end else begin
      if (ev.loop_load)
        count <= ev.loop_value;
      else if (state == EVAL && code == 3'd7 && count != '0)
        count <= count_dec;

      case (state)
        IDLE: begin
          ev.con_valid <= 1'b0;
          if (ev.con_in) begin
            cap_cond <= ev.ir_cond;
            cap_data <= ev.bus_data;
            ev.busy  <= 1'b1;
            state    <= EVAL;
          end
        end
        EVAL: begin
          ev.con_out   <= result;
          ev.con_valid <= 1'b1;
          ev.busy      <= 1'b0;
          state        <= DONE;
          if (ev.con_in)
            ev.con_err <= 1'b1;
        end
        DONE: begin
          ev.con_valid <= 1'b0;
          if (ev.con_in) begin
            cap_cond <= ev.ir_cond;
            cap_data <= ev.bus_data;
            ev.busy  <= 1'b1;
            state    <= EVAL;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          ev.con_valid <= 1'b0;
          ev.busy      <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
